// File: rtl/weight_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// weight_mem_ctrl_pkg
//   Shared definitions for the weight-memory controller:
//   - CFG_W   : width of the cfg_layer / cfg_neuron fields
//   - state_t : controller FSM state encoding (IDLE / RUN)
//   - cnt_width() : counter width for a given weight count (minimum 1 bit)
// ---------------------------------------------------------------------------
package weight_mem_ctrl_pkg;

  localparam int CFG_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wcnt_wrap.sv
// ---------------------------------------------------------------------------
// wcnt_wrap
//   Per-neuron weight write counter. Advances on each write to its neuron and
//   wraps from numWeight-1 back to 0.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset (counter -> 0)
//     inc  - advance the counter this cycle
//     cnt  - current write address for this neuron
// ---------------------------------------------------------------------------
module wcnt_wrap #(
  parameter int numWeight = 3,
  parameter int CW        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(numWeight - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/weight_mem_ctrl.sv
// ---------------------------------------------------------------------------
// weight_mem_ctrl
//   Loads per-neuron weight memories from a config stream and sequences the
//   weight reads for one inference pass.
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     cfg_valid/ready   - config beat handshake (ready only in IDLE)
//     cfg_layer/neuron  - beat target; only beats for layerNo are written
//     cfg_data          - weight value
//     start             - begin a read pass (IDLE only)
//     in_valid          - one input activation this cycle (RUN only)
//     mem_wen/waddr/win - one-hot write port to the weight memories
//     mem_ren/raddr     - broadcast read port
//     wt_valid          - memory read data valid (mem_ren delayed by one)
//     busy              - in RUN
//     done              - one-cycle pulse with the final wt_valid of a pass
//     cfg_err           - sticky out-of-range neuron index flag
// ---------------------------------------------------------------------------
module weight_mem_ctrl
  import weight_mem_ctrl_pkg::*;
#(
  parameter int numNeuron    = 4,
  parameter int numWeight    = 3,
  parameter int layerNo      = 1,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [CFG_W-1:0]        cfg_layer,
  input  logic [CFG_W-1:0]        cfg_neuron,
  input  logic [dataWidth-1:0]    cfg_data,
  output logic                    cfg_ready,
  input  logic                    start,
  input  logic                    in_valid,
  output logic [numNeuron-1:0]    mem_wen,
  output logic [addressWidth-1:0] mem_waddr,
  output logic [dataWidth-1:0]    mem_win,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_raddr,
  output logic                    wt_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int            CW   = cnt_width(numWeight);
  localparam logic [CW-1:0] LAST = CW'(numWeight - 1);

  state_t        r_state;
  logic [CW-1:0] r_rcnt;
  logic          r_wt_valid;
  logic          r_done;
  logic          r_err;

  logic                 w_accept;
  logic                 w_hit_layer;
  logic                 w_in_range;
  logic                 w_wr;
  logic [numNeuron-1:0] w_wen;
  logic [CW-1:0]        w_sel_wcnt;
  logic [CW-1:0]        w_wcnt [numNeuron];
  logic                 w_ren;

  assign cfg_ready   = (r_state == ST_IDLE);
  assign w_accept    = cfg_valid && cfg_ready && !rst;
  assign w_hit_layer = (cfg_layer == CFG_W'(layerNo));
  assign w_in_range  = ({24'd0, cfg_neuron} < 32'(numNeuron));
  assign w_wr        = w_accept && w_hit_layer && w_in_range;

  // Decode the target neuron and pick its write counter; compares against
  // every valid index so an out-of-range cfg_neuron never indexes the array.
  always_comb begin
    w_wen      = '0;
    w_sel_wcnt = '0;
    for (int unsigned n = 0; n < numNeuron; n++) begin
      if (cfg_neuron == CFG_W'(n)) begin
        w_wen[n]   = w_wr;
        w_sel_wcnt = w_wcnt[n];
      end
    end
  end

  for (genvar g = 0; g < numNeuron; g++) begin : g_wcnt
    wcnt_wrap #(
      .numWeight (numWeight),
      .CW        (CW)
    ) u_wcnt (
      .clk (clk),
      .rst (rst),
      .inc (w_wen[g]),
      .cnt (w_wcnt[g])
    );
  end

  assign mem_wen   = w_wen;
  assign mem_waddr = w_wr ? addressWidth'(w_sel_wcnt) : '0;
  assign mem_win   = w_wr ? cfg_data : '0;

  assign w_ren     = (r_state == ST_RUN) && in_valid && !rst;
  assign mem_ren   = w_ren;
  assign mem_raddr = addressWidth'(r_rcnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rcnt     <= '0;
      r_wt_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wt_valid <= w_ren;
      r_done     <= w_ren && (r_rcnt == LAST);
      if (w_accept && w_hit_layer && !w_in_range) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_rcnt  <= '0;
          end
        end
        ST_RUN: begin
          if (w_ren) begin
            if (r_rcnt == LAST) begin
              r_rcnt  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wt_valid = r_wt_valid;
  assign done     = r_done;
  assign busy     = (r_state == ST_RUN);
  assign cfg_err  = r_err;

endmodule

// File: tb/tb_weight_mem_ctrl.sv
module tb_weight_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [7:0]  cfg_layer;
  logic [7:0]  cfg_neuron;
  logic [15:0] cfg_data;
  logic        cfg_ready;
  logic        start;
  logic        in_valid;
  logic [3:0]  mem_wen;
  logic [9:0]  mem_waddr;
  logic [15:0] mem_win;
  logic        mem_ren;
  logic [9:0]  mem_raddr;
  logic        wt_valid;
  logic        busy;
  logic        done;
  logic        cfg_err;

  weight_mem_ctrl #(
    .numNeuron    (4),
    .numWeight    (3),
    .layerNo      (1),
    .addressWidth (10),
    .dataWidth    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_layer  (cfg_layer),
    .cfg_neuron (cfg_neuron),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .start      (start),
    .in_valid   (in_valid),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_win    (mem_win),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .wt_valid   (wt_valid),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  layer;
    logic [7:0]  neuron;
    logic [15:0] data;
    logic [3:0]  wen;
    logic [9:0]  waddr;
    logic [15:0] win;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  // one read beat in RUN with expected address and wt_valid
  task automatic read_beat(input int addr, input logic exp_wtv);
    in_valid = 1'b1;
    #1;
    chk("rd_ren", 32'(mem_ren), 32'd1);
    chk("rd_raddr", 32'(mem_raddr), 32'(addr));
    chk("rd_wtv", 32'(wt_valid), 32'(exp_wtv));
    chk("rd_done_low", 32'(done), 32'd0);
    @(negedge clk);
  endtask

  task automatic start_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic end_pass_check();
    in_valid = 1'b0;
    #1;
    chk("end_done", 32'(done), 32'd1);
    chk("end_wtv", 32'(wt_valid), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_ren", 32'(mem_ren), 32'd0);
    @(negedge clk);
    #1;
    chk("done_one_pulse", 32'(done), 32'd0);
    chk("wtv_after", 32'(wt_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int iv[4];
    int ea[4];
    int ew[4];

    vecs[0]  = '{8'd1, 8'd2, 16'h00A1, 4'b0100, 10'd0, 16'h00A1, 1'b0};
    vecs[1]  = '{8'd1, 8'd2, 16'h00B2, 4'b0100, 10'd1, 16'h00B2, 1'b0};
    vecs[2]  = '{8'd1, 8'd2, 16'h00C3, 4'b0100, 10'd2, 16'h00C3, 1'b0};
    vecs[3]  = '{8'd1, 8'd2, 16'h00D4, 4'b0100, 10'd0, 16'h00D4, 1'b0};
    vecs[4]  = '{8'd2, 8'd2, 16'h00E5, 4'b0000, 10'd0, 16'h0000, 1'b0};
    vecs[5]  = '{8'd1, 8'd2, 16'h00F6, 4'b0100, 10'd1, 16'h00F6, 1'b0};
    vecs[6]  = '{8'd1, 8'd0, 16'h0011, 4'b0001, 10'd0, 16'h0011, 1'b0};
    vecs[7]  = '{8'd1, 8'd3, 16'h0022, 4'b1000, 10'd0, 16'h0022, 1'b0};
    vecs[8]  = '{8'd1, 8'd0, 16'h0033, 4'b0001, 10'd1, 16'h0033, 1'b0};
    vecs[9]  = '{8'd1, 8'd7, 16'h0044, 4'b0000, 10'd0, 16'h0000, 1'b1};
    vecs[10] = '{8'd0, 8'd1, 16'h0055, 4'b0000, 10'd0, 16'h0000, 1'b1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_layer = '0; cfg_neuron = '0;
    cfg_data = '0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wtv", 32'(wt_valid), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_ren", 32'(mem_ren), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_ready", 32'(cfg_ready), 32'd1);

    // config beats
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_layer = vecs[i].layer;
      cfg_neuron = vecs[i].neuron; cfg_data = vecs[i].data;
      #1;
      chk($sformatf("v%0d_wen", i), 32'(mem_wen), 32'(vecs[i].wen));
      chk($sformatf("v%0d_waddr", i), 32'(mem_waddr), 32'(vecs[i].waddr));
      chk($sformatf("v%0d_win", i), 32'(mem_win), 32'(vecs[i].win));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_err", i), 32'(cfg_err), 32'(vecs[i].err));
    end
    @(negedge clk);
    cfg_valid = 1'b0;

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    #1;
    chk("idle_ren", 32'(mem_ren), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;

    // straight 3-read pass
    start_pass();
    read_beat(0, 1'b0);
    read_beat(1, 1'b1);
    read_beat(2, 1'b1);
    end_pass_check();
    chk("err_sticky", 32'(cfg_err), 32'd1);

    // start in RUN is ignored; pattern 1,0,1,1 with a cfg beat during RUN
    iv = '{1, 0, 1, 1};
    ea = '{0, 0, 1, 2};
    ew = '{0, 1, 0, 1};
    start_pass();
    for (int i = 0; i < 4; i++) begin
      in_valid = iv[i][0];
      start = (i == 2);
      if (i == 1) begin
        cfg_valid = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd0; cfg_data = 16'h0BAD;
      end else begin
        cfg_valid = 1'b0;
      end
      #1;
      chk($sformatf("p%0d_ren", i), 32'(mem_ren), 32'(iv[i]));
      chk($sformatf("p%0d_wtv", i), 32'(wt_valid), 32'(ew[i]));
      if (iv[i] != 0) chk($sformatf("p%0d_raddr", i), 32'(mem_raddr), 32'(ea[i]));
      if (i == 1) begin
        chk("run_ready", 32'(cfg_ready), 32'd0);
        chk("run_wen", 32'(mem_wen), 32'd0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    end_pass_check();

    // reset mid-pass
    start_pass();
    read_beat(0, 1'b0);
    read_beat(1, 1'b1);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("rstrun_ren", 32'(mem_ren), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_wtv", 32'(wt_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err_clr", 32'(cfg_err), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_done2", 32'(done), 32'd0);
    start_pass();
    read_beat(0, 1'b0);
    read_beat(1, 1'b1);
    read_beat(2, 1'b1);
    end_pass_check();

    // start and cfg beat in the same IDLE cycle
    start = 1'b1;
    cfg_valid = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd1; cfg_data = 16'h0077;
    #1;
    chk("sc_wen", 32'(mem_wen), 32'b0010);
    chk("sc_waddr", 32'(mem_waddr), 32'd0);
    chk("sc_win", 32'(mem_win), 32'h0077);
    @(negedge clk);
    start = 1'b0;
    cfg_valid = 1'b0;
    #1;
    chk("sc_busy", 32'(busy), 32'd1);
    chk("sc_ready", 32'(cfg_ready), 32'd0);
    read_beat(0, 1'b0);
    read_beat(1, 1'b1);
    read_beat(2, 1'b1);
    end_pass_check();
    cfg_valid = 1'b1; cfg_layer = 8'd1; cfg_neuron = 8'd1; cfg_data = 16'h0088;
    #1;
    chk("sc_next_waddr", 32'(mem_waddr), 32'd1);
    chk("sc_next_wen", 32'(mem_wen), 32'b0010);
    @(negedge clk);
    cfg_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
